// File: rtl/ysyx_22050854_csr_pkg.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// ysyx_22050854_csr_pkg
// Shared machine-mode CSR definitions used by the trap unit and its neighbours:
//   - CSR addresses (mstatus, mie, mtvec, mepc, mcause, mip)
//   - mstatus field positions (MIE, MPIE, MPP)
//   - mcause values for the machine timer interrupt and ecall from M-mode
//   - trap sequencer state encoding
//   - mstatus rewrite helpers for trap entry and mret
// ----------------------------------------------------------------------------
package ysyx_22050854_csr_pkg;

    localparam int CSR_XLEN = 64;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [CSR_XLEN-1:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
    localparam logic [CSR_XLEN-1:0] CAUSE_ECALL_M = 64'd11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SAVE       = 3'd1,
        ST_STATUS     = 3'd2,
        ST_RET_STATUS = 3'd3,
        ST_RET_EPC    = 3'd4,
        ST_REDIRECT   = 3'd5
    } trap_state_e;

    // Trap entry: stash MIE into MPIE, disable interrupts, previous mode = M.
    function automatic logic [CSR_XLEN-1:0] mstatus_on_trap(input logic [CSR_XLEN-1:0] old_v);
        logic [CSR_XLEN-1:0] v;
        v                                = old_v;
        v[MSTATUS_MPIE]                  = old_v[MSTATUS_MIE];
        v[MSTATUS_MIE]                   = 1'b0;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return v;
    endfunction

    // mret: restore MIE from MPIE, set MPIE, MPP stays M (only M-mode exists).
    function automatic logic [CSR_XLEN-1:0] mstatus_on_mret(input logic [CSR_XLEN-1:0] old_v);
        logic [CSR_XLEN-1:0] v;
        v                                = old_v;
        v[MSTATUS_MIE]                   = old_v[MSTATUS_MPIE];
        v[MSTATUS_MPIE]                  = 1'b1;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return v;
    endfunction

endpackage

// File: rtl/ysyx_22050854_trap_unit.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// ysyx_22050854_trap_unit
// Sequences machine-mode trap entry (timer interrupt, ecall) and mret through
// the CSR file's single read port and two write ports, then issues a one-cycle
// PC redirect to fetch. The pipeline stalls while busy is high.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   timer_interrupt        level interrupt request from the CSR file
//   commit_pc              PC of the oldest not-yet-retired instruction
//   ecall_valid/mret_valid requests at commit, held until trap_ack
//   csr_ren/raddr/rdata    CSR read port (rdata combinational, same cycle)
//   csr_wen1/waddr1/wdata1 CSR write port 1 (mepc, mstatus)
//   csr_wen2/waddr2/wdata2 CSR write port 2 (mcause)
//   trap_ack               one-cycle pulse when a request is accepted
//   busy                   high in every state except IDLE
//   redirect_valid/pc      one-cycle redirect to the trap vector / mepc
// ----------------------------------------------------------------------------
module ysyx_22050854_trap_unit
    import ysyx_22050854_csr_pkg::*;
#(
    parameter int XLEN    = CSR_XLEN,
    parameter int HOLDOFF = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            timer_interrupt,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            ecall_valid,
    input  logic            mret_valid,
    output logic            csr_ren,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_wen1,
    output logic [11:0]     csr_waddr1,
    output logic [XLEN-1:0] csr_wdata1,
    output logic            csr_wen2,
    output logic [11:0]     csr_waddr2,
    output logic [XLEN-1:0] csr_wdata2,
    output logic            trap_ack,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int HOLD_W = $clog2(HOLDOFF + 2);

    trap_state_e         state_r;
    logic [HOLD_W-1:0]   holdoff_r;
    logic [XLEN-1:0]     epc_r;
    logic [XLEN-1:0]     cause_r;
    logic [XLEN-1:0]     status_new_r;
    logic [XLEN-1:0]     target_r;

    logic                ren_r;
    logic [11:0]         raddr_r;
    logic                wen1_r;
    logic [11:0]         waddr1_r;
    logic                wen2_r;
    logic [11:0]         waddr2_r;
    logic                ack_r;
    logic                busy_r;
    logic                redirect_r;

    logic                take_irq_s;
    logic                take_trap_s;

    logic [XLEN-1:0]     wdata1_s;
    logic [XLEN-1:0]     wdata2_s;
    logic [XLEN-1:0]     redirect_pc_s;

    // Interrupts wait out the holdoff; ecall shares the trap path with them.
    assign take_irq_s  = timer_interrupt && (holdoff_r == HOLD_W'(0));
    assign take_trap_s = take_irq_s || ecall_valid;

    // Trap sequencer: state, latched trap context and registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            epc_r        <= {XLEN{1'b0}};
            cause_r      <= {XLEN{1'b0}};
            status_new_r <= {XLEN{1'b0}};
            target_r     <= {XLEN{1'b0}};
            ren_r        <= 1'b0;
            raddr_r      <= 12'h000;
            wen1_r       <= 1'b0;
            waddr1_r     <= 12'h000;
            wen2_r       <= 1'b0;
            waddr2_r     <= 12'h000;
            ack_r        <= 1'b0;
            busy_r       <= 1'b0;
            redirect_r   <= 1'b0;
        end else begin
            // Idle values; each state below overrides what it drives next cycle.
            ren_r      <= 1'b0;
            raddr_r    <= 12'h000;
            wen1_r     <= 1'b0;
            waddr1_r   <= 12'h000;
            wen2_r     <= 1'b0;
            waddr2_r   <= 12'h000;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            redirect_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (take_trap_s) begin
                        // An interrupt taken alongside an ecall records the ecall PC;
                        // the ecall stays pending and re-executes after return.
                        epc_r    <= commit_pc;
                        cause_r  <= take_irq_s ? CAUSE_MTI : CAUSE_ECALL_M;
                        state_r  <= ST_SAVE;
                        ack_r    <= 1'b1;
                        busy_r   <= 1'b1;
                        wen1_r   <= 1'b1;
                        waddr1_r <= CSR_MEPC;
                        wen2_r   <= 1'b1;
                        waddr2_r <= CSR_MCAUSE;
                        ren_r    <= 1'b1;
                        raddr_r  <= CSR_MSTATUS;
                    end else if (mret_valid) begin
                        state_r  <= ST_RET_STATUS;
                        ack_r    <= 1'b1;
                        busy_r   <= 1'b1;
                        wen1_r   <= 1'b1;
                        waddr1_r <= CSR_MSTATUS;
                        ren_r    <= 1'b1;
                        raddr_r  <= CSR_MSTATUS;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SAVE: begin
                    status_new_r <= mstatus_on_trap(csr_rdata);
                    state_r      <= ST_STATUS;
                    busy_r       <= 1'b1;
                    wen1_r       <= 1'b1;
                    waddr1_r     <= CSR_MSTATUS;
                    ren_r        <= 1'b1;
                    raddr_r      <= CSR_MTVEC;
                end
                ST_STATUS: begin
                    // Direct mode only: the mode bits are dropped from mtvec.
                    target_r   <= {csr_rdata[XLEN-1:2], 2'b00};
                    state_r    <= ST_REDIRECT;
                    busy_r     <= 1'b1;
                    redirect_r <= 1'b1;
                end
                ST_RET_STATUS: begin
                    state_r <= ST_RET_EPC;
                    busy_r  <= 1'b1;
                    ren_r   <= 1'b1;
                    raddr_r <= CSR_MEPC;
                end
                ST_RET_EPC: begin
                    target_r   <= csr_rdata;
                    state_r    <= ST_REDIRECT;
                    busy_r     <= 1'b1;
                    redirect_r <= 1'b1;
                end
                ST_REDIRECT: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Holdoff: reloaded whenever mstatus is written, then counts down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdoff_r <= HOLD_W'(0);
        end else if ((state_r == ST_STATUS) || (state_r == ST_RET_STATUS)) begin
            holdoff_r <= HOLD_W'(HOLDOFF);
        end else if (holdoff_r != HOLD_W'(0)) begin
            holdoff_r <= holdoff_r - HOLD_W'(1);
        end else begin
            holdoff_r <= holdoff_r;
        end
    end

    // Write data and redirect PC, zero whenever the matching enable is low.
    // The mret mstatus update needs the same-cycle read, so it is formed here.
    always_comb begin
        wdata1_s      = {XLEN{1'b0}};
        wdata2_s      = {XLEN{1'b0}};
        redirect_pc_s = {XLEN{1'b0}};
        case (state_r)
            ST_SAVE: begin
                wdata1_s = epc_r;
                wdata2_s = cause_r;
            end
            ST_STATUS: begin
                wdata1_s = status_new_r;
            end
            ST_RET_STATUS: begin
                wdata1_s = mstatus_on_mret(csr_rdata);
            end
            ST_REDIRECT: begin
                redirect_pc_s = target_r;
            end
            default: begin
                wdata1_s = {XLEN{1'b0}};
            end
        endcase
    end

    assign csr_ren        = ren_r;
    assign csr_raddr      = raddr_r;
    assign csr_wen1       = wen1_r;
    assign csr_waddr1     = waddr1_r;
    assign csr_wdata1     = wdata1_s;
    assign csr_wen2       = wen2_r;
    assign csr_waddr2     = waddr2_r;
    assign csr_wdata2     = wdata2_s;
    assign trap_ack       = ack_r;
    assign busy           = busy_r;
    assign redirect_valid = redirect_r;
    assign redirect_pc    = redirect_pc_s;

endmodule

// File: tb/tb_ysyx_22050854_trap_unit.sv
`timescale 1ns/1ps
// Scoreboarded bench for ysyx_22050854_trap_unit with a small behavioural
// CSR file. Stimulus pushes expected ack/write/redirect events; the monitor
// pops and compares them whenever the DUT presents one.
module tb_ysyx_22050854_trap_unit;

    localparam int K_ACK = 0;
    localparam int K_WR1 = 1;
    localparam int K_WR2 = 2;
    localparam int K_RED = 3;

    localparam logic [63:0] C_IRQ = 64'h8000_0000_0000_0007;
    localparam logic [63:0] C_ECALL = 64'd11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        timer_interrupt = 1'b0;
    logic [63:0] commit_pc = 64'h0;
    logic        ecall_valid = 1'b0;
    logic        mret_valid = 1'b0;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic        csr_wen1;
    logic [11:0] csr_waddr1;
    logic [63:0] csr_wdata1;
    logic        csr_wen2;
    logic [11:0] csr_waddr2;
    logic [63:0] csr_wdata2;
    logic        trap_ack;
    logic        busy;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // CSR file model
    logic [63:0] m_mstatus = 64'h0;
    logic [63:0] m_mtvec   = 64'h0;
    logic [63:0] m_mepc    = 64'h0;
    logic [63:0] m_mcause  = 64'h0;
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [63:0] pre_data = 64'h0;

    ysyx_22050854_trap_unit #(.XLEN(64), .HOLDOFF(2)) dut (
        .clk(clk), .rst(rst), .timer_interrupt(timer_interrupt),
        .commit_pc(commit_pc), .ecall_valid(ecall_valid), .mret_valid(mret_valid),
        .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_wen1(csr_wen1), .csr_waddr1(csr_waddr1), .csr_wdata1(csr_wdata1),
        .csr_wen2(csr_wen2), .csr_waddr2(csr_waddr2), .csr_wdata2(csr_wdata2),
        .trap_ack(trap_ack), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic model_wr(input logic [11:0] a, input logic [63:0] d);
        case (a)
            12'h300: m_mstatus <= d;
            12'h305: m_mtvec   <= d;
            12'h341: m_mepc    <= d;
            12'h342: m_mcause  <= d;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (pre_en) model_wr(pre_addr, pre_data);
        if (rst && csr_wen1) model_wr(csr_waddr1, csr_wdata1);
        if (rst && csr_wen2) model_wr(csr_waddr2, csr_wdata2);
    end

    always_comb begin
        csr_rdata = 64'h0;
        if (csr_ren) begin
            case (csr_raddr)
                12'h300: csr_rdata = m_mstatus;
                12'h305: csr_rdata = m_mtvec;
                12'h341: csr_rdata = m_mepc;
                12'h342: csr_rdata = m_mcause;
                default: csr_rdata = 64'h0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [11:0] a, input logic [63:0] d);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic push_trap(input logic [63:0] pc, input logic [63:0] cause,
                             input logic [63:0] mst, input logic [63:0] vec);
        push(K_ACK, 12'h000, 64'h0);
        push(K_WR1, 12'h341, pc);
        push(K_WR2, 12'h342, cause);
        push(K_WR1, 12'h300, mst);
        push(K_RED, 12'h000, vec);
    endtask

    task automatic push_mret(input logic [63:0] mst, input logic [63:0] epc);
        push(K_ACK, 12'h000, 64'h0);
        push(K_WR1, 12'h300, mst);
        push(K_RED, 12'h000, epc);
    endtask

    task automatic sb_pop(input int kind, input logic [11:0] a, input logic [63:0] d);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%0d addr=0x%0h data=0x%0h expected nothing", kind, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.addr !== a || e.data !== d) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d addr=0x%0h data=0x%0h expected kind=%0d addr=0x%0h data=0x%0h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: compare every presented event against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (trap_ack)       sb_pop(K_ACK, 12'h000, 64'h0);
            if (csr_wen1)       sb_pop(K_WR1, csr_waddr1, csr_wdata1);
            if (csr_wen2)       sb_pop(K_WR2, csr_waddr2, csr_wdata2);
            if (redirect_valid) sb_pop(K_RED, 12'h000, redirect_pc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [11:0] a, input logic [63:0] d);
        pre_en = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // Returns the number of negedges until trap_ack (0 = timed out).
    task automatic wait_ack(input string name, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (trap_ack === 1'b1) begin
                cyc = i;
                break;
            end
        end
        chk(name, 64'(cyc != 0), 64'd1);
    endtask

    function automatic logic any_out();
        return |{csr_ren, csr_raddr, csr_wen1, csr_waddr1, csr_wdata1, csr_wen2,
                 csr_waddr2, csr_wdata2, trap_ack, busy, redirect_valid, redirect_pc};
    endfunction

    initial begin
        int cyc;
        int first;
        int n_ack;

        // Reset state
        #2;
        chk("reset_outputs_zero", 64'(any_out()), 64'd0);
        step(2);
        rst = 1'b1;
        step(1);
        chk("idle_busy", 64'(busy), 64'd0);

        // ecall trap entry
        preset(12'h300, 64'h8);
        preset(12'h305, 64'h8000_0003);
        commit_pc = 64'h8000_0100;
        push_trap(64'h8000_0100, C_ECALL, 64'h1880, 64'h8000_0000);
        ecall_valid = 1'b1;
        wait_ack("ecall_ack", cyc);
        ecall_valid = 1'b0;
        chk("ecall_busy_c1", 64'(busy), 64'd1);
        @(negedge clk);
        chk("ecall_busy_c2", 64'(busy), 64'd1);
        @(negedge clk);
        chk("ecall_redirect_c3", 64'(redirect_valid), 64'd1);
        chk("ecall_busy_c3", 64'(busy), 64'd1);
        @(negedge clk);
        chk("ecall_busy_c4", 64'(busy), 64'd0);
        chk("ecall_mepc", m_mepc, 64'h8000_0100);
        chk("ecall_mcause", m_mcause, C_ECALL);
        chk("ecall_mstatus", m_mstatus, 64'h1880);

        // Interrupt and ecall together: interrupt first, ecall re-executes
        step(3);
        commit_pc = 64'h200;
        push_trap(64'h200, C_IRQ, 64'h1800, 64'h8000_0000);
        push_trap(64'h200, C_ECALL, 64'h1800, 64'h8000_0000);
        timer_interrupt = 1'b1;
        ecall_valid = 1'b1;
        wait_ack("irq_ecall_ack", cyc);
        timer_interrupt = 1'b0;
        repeat (3) @(negedge clk);
        chk("irq_mcause", m_mcause, C_IRQ);
        chk("irq_mepc", m_mepc, 64'h200);
        wait_ack("ecall_replay_ack", cyc);
        chk("ecall_replay_cycle", 64'(cyc), 64'd1);
        ecall_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ecall_replay_mcause", m_mcause, C_ECALL);

        // mret, with timer_interrupt held high across the return
        step(2);
        preset(12'h300, 64'h1880);
        preset(12'h341, 64'h8000_0104);
        commit_pc = 64'h400;
        push_mret(64'h1888, 64'h8000_0104);
        push_trap(64'h400, C_IRQ, 64'h1880, 64'h8000_0000);
        mret_valid = 1'b1;
        wait_ack("mret_ack", cyc);
        timer_interrupt = 1'b1;
        @(posedge clk);
        #1;
        mret_valid = 1'b0;
        first = 0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) chk("mret_redirect_c3", 64'(redirect_valid), 64'd1);
            if (c == 4) chk("mret_mstatus", m_mstatus, 64'h1888);
            if (trap_ack && first == 0) begin
                first = c;
                timer_interrupt = 1'b0;
            end
        end
        chk("irq_holdoff_cycle", 64'(first), 64'd5);
        chk("irq2_mstatus", m_mstatus, 64'h1880);
        chk("irq2_mepc", m_mepc, 64'h400);

        // ecall raised while busy with an mret
        step(2);
        commit_pc = 64'h500;
        push_mret(64'h1888, 64'h400);
        push_trap(64'h500, C_ECALL, 64'h1880, 64'h8000_0000);
        mret_valid = 1'b1;
        wait_ack("mret2_ack", cyc);
        ecall_valid = 1'b1;
        @(posedge clk);
        #1;
        mret_valid = 1'b0;
        first = 0;
        n_ack = 0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (trap_ack) begin
                n_ack++;
                if (first == 0) first = c;
                ecall_valid = 1'b0;
            end
        end
        chk("busy_ecall_first_ack", 64'(first), 64'd5);
        chk("busy_ecall_ack_count", 64'(n_ack), 64'd1);

        // Reset in the middle of STATUS
        step(2);
        commit_pc = 64'h600;
        push(K_ACK, 12'h000, 64'h0);
        push(K_WR1, 12'h341, 64'h600);
        push(K_WR2, 12'h342, C_ECALL);
        ecall_valid = 1'b1;
        wait_ack("rst_ecall_ack", cyc);
        ecall_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset_outputs_zero", 64'(any_out()), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        step(1);
        rst = 1'b1;
        step(3);
        chk("midreset_mepc", m_mepc, 64'h600);
        chk("midreset_mstatus_kept", m_mstatus, 64'h1880);
        chk("post_reset_idle", 64'(busy), 64'd0);

        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050854_trap_unit.md
# ysyx_22050854_trap_unit

- Drives the write side of the machine-mode CSR register file on trap entry and `mret`.
- Consumes `timer_interrupt` and the CSR file's single read port.
- Sequences the mepc/mcause/mstatus updates through the two CSR write ports, reads mtvec/mepc, and issues a one-cycle PC redirect to fetch.
- Sits between the commit stage and the CSR file; the pipeline stalls while it is busy.

## Interface
- `XLEN`, 64, datapath width
- `HOLDOFF`, 2, cycles after any mstatus write during which `timer_interrupt` is ignored (covers CSR-file mip/interrupt register lag)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `timer_interrupt`  in  1  level interrupt request from CSR file
- `commit_pc`  in  XLEN  PC of the oldest not-yet-retired instruction
- `ecall_valid`  in  1  ecall at commit; held until `trap_ack`
- `mret_valid`  in  1  mret at commit; held until `trap_ack`
- `csr_ren`  out  1  CSR read enable
- `csr_raddr`  out  12  CSR read address
- `csr_rdata`  in  XLEN  CSR read data, combinational, same cycle
- `csr_wen1`  out  1  write port 1 enable
- `csr_waddr1`  out  12  write port 1 address
- `csr_wdata1`  out  XLEN  write port 1 data
- `csr_wen2`  out  1  write port 2 enable
- `csr_waddr2`  out  12  write port 2 address
- `csr_wdata2`  out  XLEN  write port 2 data
- `trap_ack`  out  1  one-cycle pulse: request accepted
- `busy`  out  1  high in every state except IDLE; pipeline stalls
- `redirect_valid`  out  1  one-cycle pulse
- `redirect_pc`  out  XLEN  target PC, valid with `redirect_valid`

## Operation
- States: IDLE, SAVE, STATUS, RET_STATUS, RET_EPC, REDIRECT.
- IDLE accepts at most one event per cycle. Priority:
  - interrupt: `timer_interrupt` and holdoff==0
  - then `ecall_valid`
  - then `mret_valid`
- Accepting an event latches `epc`:
  - interrupt: `epc`=`commit_pc`, `cause`=0x8000_0000_0000_0007
  - ecall: `epc`=`commit_pc`, `cause`=11
- Trap path, IDLE→SAVE→STATUS→REDIRECT→IDLE.
  - SAVE: port1 writes mepc(0x341)=`epc`; port2 writes mcause(0x342)=`cause`; read mstatus(0x300) and latch it.
  - STATUS: port1 writes mstatus with MPIE[7]=old MIE[3], MIE=0, MPP[12:11]=2'b11, other bits unchanged; read mtvec(0x305) and latch `target`=rdata with bits[1:0] cleared (direct mode only).
- mret path, IDLE→RET_STATUS→RET_EPC→REDIRECT→IDLE.
  - RET_STATUS: read mstatus; port1 writes MIE=old MPIE, MPIE=1, MPP=2'b11.
  - RET_EPC: read mepc(0x341); latch `target`.
- REDIRECT: `redirect_valid`=1, `redirect_pc`=`target`.
- Holdoff counter:
  - loaded with `HOLDOFF` at the clock edge ending any state that writes mstatus (STATUS, RET_STATUS)
  - decrements to 0 and saturates
  - blocks interrupt acceptance only; it does not block ecall or mret
- When `csr_ren`/`csr_wen*` are deasserted, the corresponding addresses and data drive 0.
- Simultaneous events:
  - interrupt with ecall: interrupt wins, mepc=ecall PC, ecall not acked; it re-executes after return.
  - interrupt with mret: interrupt wins.
  - ecall with mret: ecall wins.
- Requests arriving while `busy` are ignored and not acked.

## Timing
- Reset (async assert):
  - state=IDLE; holdoff=0; `epc`, `cause`, `target` = 0
  - all outputs 0, including `busy`, `trap_ack`, `redirect_valid`, `redirect_pc`, enables, addresses and data
- Reset mid-sequence abandons the sequence; partially written CSRs remain as written.
- Accept edge is edge 0. Cycle 1 is SAVE or RET_STATUS, with `trap_ack`=1 in cycle 1 only.
- Cycle 2 is STATUS or RET_EPC. Cycle 3 is REDIRECT. Cycle 4 is IDLE, and a new request can be accepted on the edge ending cycle 4.
- `busy` is high in cycles 1–3.
- CSR writes take effect on the edge ending the writing cycle. A read of a register in the same cycle it is written returns the old value.
- Holdoff with `HOLDOFF`=2: interrupt is first acceptable in the cycle where holdoff reads 0.
  - trap path: cycle 5
  - mret path: cycle 4

## Structure
- Shared package `ysyx_22050854_csr_pkg` holds:
  - CSR address constants (mstatus, mtvec, mepc, mcause, mie, mip)
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11)
  - cause constants (MTI interrupt, ECALL_M=11)
  - state enum
- Single flat FSM; no sub-module. The mstatus update is a package function.

## Test plan
- Reset with rst=0 mid-STATUS → next cycle all outputs 0, `busy`=0, state IDLE.
- ecall at `commit_pc`=0x8000_0100, mstatus=0x8, mtvec=0x8000_0003 → mepc=0x8000_0100, mcause=11, mstatus=0x1880, `redirect_pc`=0x8000_0000 in cycle 3.
- `timer_interrupt` and `ecall_valid` both high, `commit_pc`=0x200 → mcause=0x8000_0000_0000_0007, mepc=0x200, ecall not acked, re-presented after redirect.
- mret with mstatus=0x1880, mepc=0x8000_0104 → mstatus=0x1888, `redirect_pc`=0x8000_0104 in cycle 3.
- `timer_interrupt` held high through trap return → no interrupt acceptance before holdoff reaches 0; with `HOLDOFF`=2, acceptance no earlier than cycle 4 after the mret accept edge.
- `ecall_valid` raised while `busy` → no `trap_ack` until IDLE; then accepted once, exactly one `trap_ack` pulse.
